// File: rtl/pipe_daq_pkg.sv
// Shared definitions for the DAQ pipeline read side: widths, capture FSM states
// and the layout of a buffered sample word.
package pipe_daq_pkg;

   localparam int NSAMP_MAX = 16;
   localparam int PIPW      = 192;
   localparam int EVTW      = 12;
   localparam int SMPW      = 4;
   localparam int WORDW     = 1 + EVTW + SMPW + PIPW;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_ARM  = 2'd1,
      ST_CAPT = 2'd2
   } cap_state_t;

   // Buffered word, MSB first: last flag, event number, sample index, pipeline data
   typedef struct packed {
      logic            last;
      logic [EVTW-1:0] evt;
      logic [SMPW-1:0] smp;
      logic [PIPW-1:0] data;
   } fifo_word_t;

   function automatic fifo_word_t pack_word(
      input logic            last,
      input logic [EVTW-1:0] evt,
      input logic [SMPW-1:0] smp,
      input logic [PIPW-1:0] data
   );
      fifo_word_t w;
      w.last = last;
      w.evt  = evt;
      w.smp  = smp;
      w.data = data;
      return w;
   endfunction

endpackage

// File: rtl/pipe_sync_fifo.sv
// Single-clock first-word-fall-through FIFO: the head word is visible on rd_data
// the cycle after it is written. A push into a full FIFO is accepted only with a pop.
module pipe_sync_fifo #(
   parameter int WIDTH = 209,
   parameter int AW    = 4
) (
   input  logic             RDCLK,
   input  logic             trst,
   input  logic             wr_en,
   input  logic [WIDTH-1:0] wr_data,
   input  logic             rd_en,
   output logic [WIDTH-1:0] rd_data,
   output logic             full,
   output logic             empty,
   output logic [AW:0]      count
);

   localparam int          DEPTH   = 1 << AW;
   localparam logic [AW:0] PTR_ONE = (AW+1)'(1);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW:0]      wr_ptr_reg;
   logic [AW:0]      rd_ptr_reg;
   logic             push;
   logic             pop;

   // Extra pointer MSB distinguishes full from empty when the indices match
   assign empty   = (wr_ptr_reg == rd_ptr_reg);
   assign full    = (wr_ptr_reg[AW] != rd_ptr_reg[AW]) &&
                    (wr_ptr_reg[AW-1:0] == rd_ptr_reg[AW-1:0]);
   assign count   = wr_ptr_reg - rd_ptr_reg;
   assign pop     = rd_en & ~empty;
   assign push    = wr_en & (~full | pop);
   assign rd_data = mem[rd_ptr_reg[AW-1:0]];

   always_ff @(posedge RDCLK or posedge trst) begin
      if (trst) begin
         wr_ptr_reg <= '0;
         rd_ptr_reg <= '0;
      end else begin
         if (push) wr_ptr_reg <= wr_ptr_reg + PTR_ONE;
         if (pop)  rd_ptr_reg <= rd_ptr_reg + PTR_ONE;
      end
   end

   always_ff @(posedge RDCLK) begin
      if (push) mem[wr_ptr_reg[AW-1:0]] <= wr_data;
   end

endmodule

// File: rtl/pipe_l1a_capture.sv
// L1A-triggered capture of NSAMP consecutive pipeline words per event, tagged with
// event number and sample index, buffered in a FWFT FIFO with valid/ready drain.
module pipe_l1a_capture
   import pipe_daq_pkg::*;
#(
   parameter int NSAMP    = 8,
   parameter int FIFO_AW  = 4,
   parameter int MAX_PEND = 7
) (
   input  logic            CLK,
   input  logic            RST,
   input  logic            L1A,
   input  logic            SMPL_EN,
   input  logic [PIPW-1:0] PIPOUT,
   output logic [PIPW-1:0] DOUT,
   output logic [SMPW-1:0] DOUT_SMP,
   output logic [EVTW-1:0] DOUT_EVT,
   output logic            DOUT_LAST,
   output logic            DOUT_VLD,
   input  logic            DOUT_RDY,
   output logic            BUSY,
   output logic            L1A_ERR,
   output logic            OVFL
);

   localparam int               PENDW    = $clog2(MAX_PEND + 1);
   localparam logic [PENDW-1:0] PEND_MAX = PENDW'(MAX_PEND);
   localparam logic [PENDW-1:0] PEND_ONE = PENDW'(1);
   localparam logic [SMPW-1:0]  SMP_LAST = SMPW'(NSAMP - 1);
   localparam logic [SMPW-1:0]  SMP_ONE  = SMPW'(1);
   localparam logic [EVTW-1:0]  EVT_ONE  = EVTW'(1);

   cap_state_t       state_reg, state_next;
   logic [PENDW-1:0] pending_reg, pending_next;
   logic [EVTW-1:0]  evt_cnt_reg;
   logic [EVTW-1:0]  cur_evt_reg, cur_evt_next;
   logic [SMPW-1:0]  smp_reg, smp_next;
   logic             l1a_err_reg;
   logic             ovfl_reg;

   logic             l1a_acc;
   logic             l1a_drop;
   logic             start;
   logic [EVTW-1:0]  start_evt;
   logic             wr_en;
   fifo_word_t       wr_word;
   fifo_word_t       rd_word;
   logic             fifo_full;
   logic             fifo_empty;
   logic [FIFO_AW:0] fifo_count;
   logic             fifo_vld;
   logic             pop;

   assign l1a_acc  = L1A & (pending_reg != PEND_MAX);
   assign l1a_drop = L1A & (pending_reg == PEND_MAX);

   // Queued events hold contiguous numbers, so the oldest one is the counter minus the queue depth
   assign start_evt = evt_cnt_reg - EVTW'(pending_reg);

   always_comb begin
      state_next   = state_reg;
      start        = 1'b0;
      wr_en        = 1'b0;
      wr_word      = '0;
      smp_next     = smp_reg;
      cur_evt_next = cur_evt_reg;
      case (state_reg)
         ST_IDLE: begin
            if (pending_reg != '0) state_next = ST_ARM;
         end
         ST_ARM: begin
            if (SMPL_EN) begin
               start        = 1'b1;
               wr_en        = 1'b1;
               wr_word      = pack_word(NSAMP == 1, start_evt, '0, PIPOUT);
               cur_evt_next = start_evt;
               smp_next     = SMP_ONE;
               if (NSAMP == 1)
                  state_next = (pending_reg > PEND_ONE) ? ST_ARM : ST_IDLE;
               else
                  state_next = ST_CAPT;
            end
         end
         ST_CAPT: begin
            if (SMPL_EN) begin
               wr_en    = 1'b1;
               wr_word  = pack_word(smp_reg == SMP_LAST, cur_evt_reg, smp_reg, PIPOUT);
               smp_next = smp_reg + SMP_ONE;
               if (smp_reg == SMP_LAST)
                  state_next = (pending_reg != '0) ? ST_ARM : ST_IDLE;
            end
         end
         default: state_next = ST_IDLE;
      endcase
   end

   always_comb begin
      pending_next = pending_reg;
      case ({l1a_acc, start})
         2'b10:   pending_next = pending_reg + PEND_ONE;
         2'b01:   pending_next = pending_reg - PEND_ONE;
         default: pending_next = pending_reg;
      endcase
   end

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         state_reg   <= ST_IDLE;
         pending_reg <= '0;
         evt_cnt_reg <= '0;
         cur_evt_reg <= '0;
         smp_reg     <= '0;
         l1a_err_reg <= 1'b0;
         ovfl_reg    <= 1'b0;
      end else begin
         state_reg   <= state_next;
         pending_reg <= pending_next;
         cur_evt_reg <= cur_evt_next;
         smp_reg     <= smp_next;
         if (l1a_acc) evt_cnt_reg <= evt_cnt_reg + EVT_ONE;
         if (l1a_drop) l1a_err_reg <= 1'b1;
         // Sample index keeps advancing on a drop so the event retains its slot timing
         if (wr_en & fifo_full & ~pop) ovfl_reg <= 1'b1;
      end
   end

   assign fifo_vld = ~fifo_empty;
   assign pop      = fifo_vld & DOUT_RDY;

   pipe_sync_fifo #(
      .WIDTH (WORDW),
      .AW    (FIFO_AW)
   ) u_fifo (
      .RDCLK   (CLK),
      .trst    (RST),
      .wr_en   (wr_en),
      .wr_data (wr_word),
      .rd_en   (DOUT_RDY),
      .rd_data (rd_word),
      .full    (fifo_full),
      .empty   (fifo_empty),
      .count   (fifo_count)
   );

   // Data outputs read zero whenever nothing is valid
   assign DOUT      = fifo_vld ? rd_word.data : '0;
   assign DOUT_SMP  = fifo_vld ? rd_word.smp  : '0;
   assign DOUT_EVT  = fifo_vld ? rd_word.evt  : '0;
   assign DOUT_LAST = fifo_vld & rd_word.last;
   assign DOUT_VLD  = fifo_vld;
   assign BUSY      = (state_reg != ST_IDLE) | (pending_reg != '0) | (fifo_count != '0);
   assign L1A_ERR   = l1a_err_reg;
   assign OVFL      = ovfl_reg;

endmodule

// File: tb/tb_pipe_l1a_capture.sv
// Directed bench for pipe_l1a_capture: single event, back-to-back events, L1A queue
// overflow, FIFO overflow with stalled drain, coincident L1A/strobe and mid-capture reset.
module tb_pipe_l1a_capture;

   logic         CLK = 1'b0;
   logic         RST = 1'b1;
   logic         L1A = 1'b0;
   logic         SMPL_EN = 1'b0;
   logic [191:0] PIPOUT = '0;
   logic [191:0] DOUT;
   logic [3:0]   DOUT_SMP;
   logic [11:0]  DOUT_EVT;
   logic         DOUT_LAST;
   logic         DOUT_VLD;
   logic         DOUT_RDY = 1'b1;
   logic         BUSY;
   logic         L1A_ERR;
   logic         OVFL;

   int total = 0;
   int bad   = 0;
   int sid   = 0;
   logic [208:0] got_q[$];

   always #5 CLK = ~CLK;

   pipe_l1a_capture #(.NSAMP(8), .FIFO_AW(4), .MAX_PEND(7)) dut (
      .CLK(CLK), .RST(RST), .L1A(L1A), .SMPL_EN(SMPL_EN), .PIPOUT(PIPOUT),
      .DOUT(DOUT), .DOUT_SMP(DOUT_SMP), .DOUT_EVT(DOUT_EVT), .DOUT_LAST(DOUT_LAST),
      .DOUT_VLD(DOUT_VLD), .DOUT_RDY(DOUT_RDY), .BUSY(BUSY), .L1A_ERR(L1A_ERR), .OVFL(OVFL)
   );

   // Each accepted transfer is recorded half a cycle before the edge that pops it
   always @(negedge CLK) begin
      if (!RST && DOUT_VLD && DOUT_RDY) begin
         got_q.push_back({DOUT_LAST, DOUT_EVT, DOUT_SMP, DOUT});
         $display("xfer evt=%0d smp=%0d last=%0b data[15:0]=%h", DOUT_EVT, DOUT_SMP, DOUT_LAST, DOUT[15:0]);
      end
   end

   function automatic logic [191:0] pat(input int s);
      logic [15:0] h;
      h = 16'hA000 ^ 16'(s);
      return {12{h}};
   endfunction

   task automatic step(input logic l1a, input logic se);
      L1A = l1a;
      SMPL_EN = se;
      PIPOUT = pat(sid);
      @(posedge CLK);
      #1;
      if (se) sid++;
      L1A = 1'b0;
      SMPL_EN = 1'b0;
   endtask

   task automatic do_reset();
      RST = 1'b1;
      L1A = 1'b0;
      SMPL_EN = 1'b0;
      DOUT_RDY = 1'b1;
      repeat (2) @(posedge CLK);
      #1;
      RST = 1'b0;
      got_q.delete();
   endtask

   task automatic test_reset();
      RST = 1'b1;
      #1;
      total++;
      if ({DOUT_VLD, BUSY, L1A_ERR, OVFL, DOUT_LAST} !== 5'b0) begin
         bad++;
         $display("FAIL reset_flags: got vld/busy/err/ovfl/last=%b want 00000", {DOUT_VLD, BUSY, L1A_ERR, OVFL, DOUT_LAST});
      end
      do_reset();
      total++;
      if ({DOUT, DOUT_SMP, DOUT_EVT} !== '0) begin
         bad++;
         $display("FAIL reset_data: got dout=%h smp=%0d evt=%0d want all 0", DOUT, DOUT_SMP, DOUT_EVT);
      end
      total++;
      if ({DOUT_VLD, BUSY} !== 2'b00) begin
         bad++;
         $display("FAIL reset_idle: got vld/busy=%b want 00", {DOUT_VLD, BUSY});
      end
   endtask

   task automatic test_single();
      int s0;
      logic [208:0] exp;
      do_reset();
      s0 = sid;
      for (int c = 0; c < 72; c++) begin
         step(c == 0, (c % 8 == 0) && (c > 0));
         if (c == 0) begin
            total++;
            if (BUSY !== 1'b1) begin
               bad++;
               $display("FAIL single_busy: got %b want 1", BUSY);
            end
         end
         if (c == 8) begin
            total++;
            if ({DOUT_VLD, DOUT_SMP, DOUT_EVT} !== {1'b1, 4'd0, 12'd0}) begin
               bad++;
               $display("FAIL single_latency: got vld=%b smp=%0d evt=%0d want vld=1 smp=0 evt=0", DOUT_VLD, DOUT_SMP, DOUT_EVT);
            end
         end
      end
      total++;
      if (BUSY !== 1'b0) begin
         bad++;
         $display("FAIL single_idle_busy: got %b want 0", BUSY);
      end
      total++;
      if (got_q.size() != 8) begin
         bad++;
         $display("FAIL single_count: got %0d want 8", got_q.size());
      end
      for (int k = 0; k < got_q.size() && k < 8; k++) begin
         exp = {(k == 7), 12'd0, 4'(k), pat(s0 + k)};
         total++;
         if (got_q[k] !== exp) begin
            bad++;
            $display("FAIL single_word%0d: got last=%b evt=%0d smp=%0d data=%h want last=%b evt=%0d smp=%0d data=%h",
                     k, got_q[k][208], got_q[k][207:196], got_q[k][195:192], got_q[k][15:0],
                     exp[208], exp[207:196], exp[195:192], exp[15:0]);
         end
      end
   endtask

   task automatic test_back_to_back();
      int s0;
      logic [208:0] exp;
      do_reset();
      s0 = sid;
      for (int c = 0; c < 200; c++)
         step((c == 0) || (c == 2) || (c == 4), (c % 8 == 7) && (c < 199));
      total++;
      if (got_q.size() != 24) begin
         bad++;
         $display("FAIL b2b_count: got %0d want 24", got_q.size());
      end
      for (int k = 0; k < got_q.size() && k < 24; k++) begin
         exp = {(k % 8 == 7), 12'(k / 8), 4'(k % 8), pat(s0 + k)};
         total++;
         if (got_q[k] !== exp) begin
            bad++;
            $display("FAIL b2b_word%0d: got last=%b evt=%0d smp=%0d data=%h want last=%b evt=%0d smp=%0d data=%h",
                     k, got_q[k][208], got_q[k][207:196], got_q[k][195:192], got_q[k][15:0],
                     exp[208], exp[207:196], exp[195:192], exp[15:0]);
         end
      end
   endtask

   task automatic test_l1a_overflow();
      int s0;
      logic [208:0] exp;
      do_reset();
      s0 = sid;
      for (int c = 0; c < 525; c++) begin
         step((c == 0) || ((c >= 8) && (c <= 15)), (c % 8 == 7) && (c < 519));
         if (c == 14) begin
            total++;
            if (L1A_ERR !== 1'b0) begin
               bad++;
               $display("FAIL l1a_err_early: got %b want 0", L1A_ERR);
            end
         end
         if (c == 15) begin
            total++;
            if (L1A_ERR !== 1'b1) begin
               bad++;
               $display("FAIL l1a_err_set: got %b want 1", L1A_ERR);
            end
         end
      end
      total++;
      if (L1A_ERR !== 1'b1) begin
         bad++;
         $display("FAIL l1a_err_sticky: got %b want 1", L1A_ERR);
      end
      total++;
      if (got_q.size() != 64) begin
         bad++;
         $display("FAIL l1aq_count: got %0d want 64", got_q.size());
      end
      for (int k = 0; k < got_q.size() && k < 64; k++) begin
         exp = {(k % 8 == 7), 12'(k / 8), 4'(k % 8), pat(s0 + k)};
         total++;
         if (got_q[k] !== exp) begin
            bad++;
            $display("FAIL l1aq_word%0d: got evt=%0d smp=%0d last=%b want evt=%0d smp=%0d last=%b",
                     k, got_q[k][207:196], got_q[k][195:192], got_q[k][208], exp[207:196], exp[195:192], exp[208]);
         end
      end
   endtask

   task automatic test_fifo_full();
      int s0;
      logic [208:0] exp;
      do_reset();
      DOUT_RDY = 1'b0;
      s0 = sid;
      for (int c = 0; c < 200; c++) begin
         step(c <= 2, (c % 8 == 7) && (c < 199));
         if (c == 134) begin
            total++;
            if (OVFL !== 1'b0) begin
               bad++;
               $display("FAIL ovfl_early: got %b want 0", OVFL);
            end
            total++;
            if ({DOUT_VLD, DOUT_EVT, DOUT_SMP, DOUT_LAST, DOUT} !== {1'b1, 12'd0, 4'd0, 1'b0, pat(s0)}) begin
               bad++;
               $display("FAIL hold_stable: got vld=%b evt=%0d smp=%0d data=%h want vld=1 evt=0 smp=0 data=%h",
                        DOUT_VLD, DOUT_EVT, DOUT_SMP, DOUT[15:0], pat(s0) & 192'hFFFF);
            end
         end
         if (c == 135) begin
            total++;
            if (OVFL !== 1'b1) begin
               bad++;
               $display("FAIL ovfl_set: got %b want 1", OVFL);
            end
         end
      end
      DOUT_RDY = 1'b1;
      repeat (20) step(1'b0, 1'b0);
      total++;
      if (got_q.size() != 16) begin
         bad++;
         $display("FAIL full_count: got %0d want 16", got_q.size());
      end
      for (int k = 0; k < got_q.size() && k < 16; k++) begin
         exp = {(k % 8 == 7), 12'(k / 8), 4'(k % 8), pat(s0 + k)};
         total++;
         if (got_q[k] !== exp) begin
            bad++;
            $display("FAIL full_word%0d: got evt=%0d smp=%0d data=%h want evt=%0d smp=%0d data=%h",
                     k, got_q[k][207:196], got_q[k][195:192], got_q[k][15:0], exp[207:196], exp[195:192], exp[15:0]);
         end
      end
   endtask

   task automatic test_coincident();
      int s0;
      logic [208:0] exp;
      do_reset();
      s0 = sid;
      for (int c = 0; c < 80; c++)
         step(c == 0, (c % 8 == 0) && (c < 72));
      total++;
      if (got_q.size() != 8) begin
         bad++;
         $display("FAIL coinc_count: got %0d want 8", got_q.size());
      end
      for (int k = 0; k < got_q.size() && k < 8; k++) begin
         exp = {(k == 7), 12'd0, 4'(k), pat(s0 + 1 + k)};
         total++;
         if (got_q[k] !== exp) begin
            bad++;
            $display("FAIL coinc_word%0d: got smp=%0d data=%h want smp=%0d data=%h",
                     k, got_q[k][195:192], got_q[k][15:0], exp[195:192], exp[15:0]);
         end
      end
   endtask

   task automatic test_rst_mid();
      int s0;
      logic [208:0] exp;
      do_reset();
      DOUT_RDY = 1'b0;
      for (int c = 0; c < 24; c++)
         step(c == 0, (c % 8 == 7));
      total++;
      if ({DOUT_VLD, DOUT_SMP} !== {1'b1, 4'd0}) begin
         bad++;
         $display("FAIL rst_pre: got vld=%b smp=%0d want vld=1 smp=0", DOUT_VLD, DOUT_SMP);
      end
      RST = 1'b1;
      #1;
      total++;
      if ({DOUT_VLD, BUSY} !== 2'b00) begin
         bad++;
         $display("FAIL rst_async: got vld/busy=%b want 00", {DOUT_VLD, BUSY});
      end
      @(posedge CLK);
      #1;
      RST = 1'b0;
      DOUT_RDY = 1'b1;
      got_q.delete();
      s0 = sid;
      for (int c = 0; c < 72; c++)
         step(c == 0, (c % 8 == 0) && (c > 0));
      total++;
      if (got_q.size() != 8) begin
         bad++;
         $display("FAIL rst_count: got %0d want 8", got_q.size());
      end
      for (int k = 0; k < got_q.size() && k < 8; k++) begin
         exp = {(k == 7), 12'd0, 4'(k), pat(s0 + k)};
         total++;
         if (got_q[k] !== exp) begin
            bad++;
            $display("FAIL rst_word%0d: got evt=%0d smp=%0d want evt=%0d smp=%0d",
                     k, got_q[k][207:196], got_q[k][195:192], exp[207:196], exp[195:192]);
         end
      end
   endtask

   initial begin
      test_reset();
      test_single();
      test_back_to_back();
      test_l1a_overflow();
      test_fifo_full();
      test_coincident();
      test_rst_mid();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
